// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequence initiator and its ack synchronizer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    RELEASE = 2'd2
  } state_e;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/reset_ack_sync.sv
// Multi-bit flop-chain synchronizer for the per-domain reset acknowledges.
// Each bit is an independent level (a domain's own rst_n), so per-bit sync is safe.
module reset_ack_sync
  import reset_seq_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_seq_initiator.sv
// Issues a registered active-low reset to downstream domains and waits for their acks.
// Optional macro RST_SEQ_HOLD_EN adds a 'hold' input that stretches the assert phase.
module reset_seq_initiator
  import reset_seq_pkg::*;
#(
  parameter int N_DOMAINS    = 2,
  parameter int PULSE_CYCLES = 16,
  parameter int ACK_TIMEOUT  = 255
) (
  input  logic                 clk,
  input  logic                 asyncrst_n,
  input  logic                 req,
`ifdef RST_SEQ_HOLD_EN
  input  logic                 hold,
`endif
  input  logic [N_DOMAINS-1:0] rst_ack_n,
  output logic                 rst_out_n,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err
);

  localparam int PW = $clog2(PULSE_CYCLES + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [PW-1:0] PULSE_MAX    = PW'(PULSE_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(ACK_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [PW-1:0]    pulse_cnt_q, pulse_cnt_d;
  logic [TW-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic             rst_out_n_q, rst_out_n_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timeout_err_q, timeout_err_d;

  logic [N_DOMAINS-1:0] ack_sync;
  logic                 ack_low, ack_high;
  logic                 start, hold_active;

  reset_ack_sync #(
    .WIDTH (N_DOMAINS)
  ) u_ack_sync (
    .clk   (clk),
    .rst_n (asyncrst_n),
    .d     (rst_ack_n),
    .q     (ack_sync)
  );

  assign ack_low  = ~|ack_sync;
  assign ack_high = &ack_sync;

`ifdef RST_SEQ_HOLD_EN
  assign start       = req | hold;
  assign hold_active = hold;
`else
  assign start       = req;
  assign hold_active = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    pulse_cnt_d   = pulse_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    done_d        = 1'b0;
    timeout_err_d = timeout_err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = ASSERT;
          pulse_cnt_d   = '0;
          tmo_cnt_d     = '0;
          timeout_err_d = 1'b0;
        end
      end
      ASSERT: begin
        if (pulse_cnt_q != PULSE_MAX) begin
          pulse_cnt_d = pulse_cnt_q + 1'b1;
        end else if (!hold_active) begin
          // Minimum pulse met; hold (when present) freezes both exit and timeout.
          if (ack_low) begin
            state_d   = RELEASE;
            tmo_cnt_d = '0;
          end else if (tmo_cnt_q == TIMEOUT_LAST) begin
            state_d       = IDLE;
            timeout_err_d = 1'b1;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
          end
        end
      end
      RELEASE: begin
        if (ack_high) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (tmo_cnt_q == TIMEOUT_LAST) begin
          state_d       = IDLE;
          timeout_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    rst_out_n_d = (state_d != ASSERT);
    busy_d      = (state_d != IDLE);
  end

  // Outputs are decoded from the next state so they are glitch-free flop outputs.
  always_ff @(posedge clk or negedge asyncrst_n) begin
    if (!asyncrst_n) begin
      state_q       <= ASSERT;
      pulse_cnt_q   <= '0;
      tmo_cnt_q     <= '0;
      rst_out_n_q   <= 1'b0;
      busy_q        <= 1'b1;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pulse_cnt_q   <= pulse_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      rst_out_n_q   <= rst_out_n_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign rst_out_n   = rst_out_n_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_reset_seq_initiator.sv
// Directed bench for reset_seq_initiator (N_DOMAINS=2, PULSE_CYCLES=4, ACK_TIMEOUT=8).
// Each downstream domain is a 2-flop reset synchronizer driven by rst_out_n.
module tb_reset_seq_initiator;

  localparam int N = 2;

  logic         clk = 1'b0;
  logic         asyncrst_n = 1'b0;
  logic         req = 1'b0;
`ifdef RST_SEQ_HOLD_EN
  logic         hold = 1'b0;
`endif
  logic [N-1:0] rst_ack_n;
  logic [N-1:0] m1_q, m2_q;
  logic [N-1:0] stuck_mask = '0;
  logic [N-1:0] stuck_val  = '0;
  logic         rst_out_n, busy, done, timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Downstream domains: async assert, synchronous release of their local reset.
  always @(posedge clk or negedge rst_out_n) begin
    if (!rst_out_n) begin
      m1_q <= '0;
      m2_q <= '0;
    end else begin
      m1_q <= '1;
      m2_q <= m1_q;
    end
  end

  assign rst_ack_n = (m2_q & ~stuck_mask) | (stuck_val & stuck_mask);

  reset_seq_initiator #(
    .N_DOMAINS    (2),
    .PULSE_CYCLES (4),
    .ACK_TIMEOUT  (8)
  ) dut (
    .clk         (clk),
    .asyncrst_n  (asyncrst_n),
    .req         (req),
`ifdef RST_SEQ_HOLD_EN
    .hold        (hold),
`endif
    .rst_ack_n   (rst_ack_n),
    .rst_out_n   (rst_out_n),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Watches one sequence from the current negedge. Cycle c=1 is the sample after
  // the first posedge. Optionally pokes req while busy to prove it is ignored.
  task automatic run_seq(input string name, input bit poke,
                         input int exp_rise, input int exp_done, input int exp_dones,
                         input int exp_idle, input int exp_te_first, input int exp_te_end);
    int rise_at, done_at, dones, idle_at, te_first, te_end;
    rise_at = -1; done_at = -1; dones = 0; idle_at = -1; te_first = -1; te_end = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) te_first = int'(timeout_err);
      if (rst_out_n && rise_at < 0) rise_at = c;
      if (done) begin
        dones++;
        if (done_at < 0) done_at = c;
      end
      if (!busy) begin
        idle_at = c;
        te_end  = int'(timeout_err);
        req     = 1'b0;
        break;
      end
      req = poke && (c % 3 == 0);
    end
    req = 1'b0;
    $display("seq %s: rise@%0d done@%0d dones=%0d idle@%0d err_start=%0d err_end=%0d",
             name, rise_at, done_at, dones, idle_at, te_first, te_end);
    check_eq({name, "_rise"}, rise_at, exp_rise);
    check_eq({name, "_done_at"}, done_at, exp_done);
    check_eq({name, "_dones"}, dones, exp_dones);
    check_eq({name, "_idle_at"}, idle_at, exp_idle);
    check_eq({name, "_err_start"}, te_first, exp_te_first);
    check_eq({name, "_err_end"}, te_end, exp_te_end);
    @(negedge clk);
    check_eq({name, "_done_width"}, int'(done), 0);
    check_eq({name, "_stay_idle"}, int'(busy), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_rst_out_n", int'(rst_out_n), 0);
    check_eq("rst_busy", int'(busy), 1);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_timeout_err", int'(timeout_err), 0);

    // Power-on sequence runs with no req.
    asyncrst_n = 1'b1;
    run_seq("power_on", 1'b0, 5, 10, 1, 10, 0, 0);

    // Software request with extra req pulses while busy.
    req = 1'b1;
    run_seq("sw_req", 1'b1, 6, 11, 1, 11, 0, 0);

    // Domain 1 never asserts: times out in ASSERT.
    stuck_mask = 2'b10; stuck_val = 2'b10;
    @(negedge clk);
    req = 1'b1;
    run_seq("assert_tmo", 1'b0, 13, -1, 0, 13, 0, 1);

    // Next request clears the sticky error and completes normally.
    stuck_mask = 2'b00;
    @(negedge clk);
    req = 1'b1;
    run_seq("recover", 1'b0, 6, 11, 1, 11, 0, 0);

    // Domain 0 never releases: times out in RELEASE.
    stuck_mask = 2'b01; stuck_val = 2'b00;
    @(negedge clk);
    req = 1'b1;
    run_seq("release_tmo", 1'b0, 6, -1, 0, 14, 0, 1);
    stuck_mask = 2'b00;

    // Asynchronous reset while in RELEASE.
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("mid_pre_rst_out_n", int'(rst_out_n), 1);
    check_eq("mid_pre_busy", int'(busy), 1);
    #2 asyncrst_n = 1'b0;
    #1;
    check_eq("mid_rst_out_n", int'(rst_out_n), 0);
    check_eq("mid_busy", int'(busy), 1);
    check_eq("mid_done", int'(done), 0);
    @(negedge clk);
    asyncrst_n = 1'b1;
    run_seq("mid_restart", 1'b0, 5, 10, 1, 10, 0, 0);

`ifdef RST_SEQ_HOLD_EN
    begin
      int low_cnt, err_cnt;
      low_cnt = 0; err_cnt = 0;
      hold = 1'b1;
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        if (!rst_out_n) low_cnt++;
        if (timeout_err) err_cnt++;
      end
      hold = 1'b0;
      check_eq("hold_low_cycles", low_cnt, 20);
      check_eq("hold_err_cycles", err_cnt, 0);
      run_seq("hold_release", 1'b0, 1, 6, 1, 6, 0, 0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
